// File: rtl/iter_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   op_e    : operation select (product low/high half, quotient, remainder)
//   state_e : control FSM state encoding
//   is_div  : true for the two divide operations
package iter_muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULLO = 2'b00,
    OP_MULHI = 2'b01,
    OP_DIVQ  = 2'b10,
    OP_DIVR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic is_div(input op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/iter_muldiv_if.sv
// Request/response bundle between the control unit and the muldiv unit.
//   start    : one-cycle request          op       : operation select
//   a_in     : multiplicand / dividend    b_in     : multiplier / divisor
//   busy     : operation in progress      done     : one-cycle completion pulse
//   div_zero : last divide had b_in == 0  result   : last completed result
// master = control unit side, slave = muldiv unit side.
interface iter_muldiv_if
  import iter_muldiv_pkg::*;
#(
  parameter int WIDTH = 16
) ();

  logic             start;
  op_e              op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, a_in, b_in,
    input  busy, done, div_zero, result
  );

  modport slave (
    input  start, op, a_in, b_in,
    output busy, done, div_zero, result
  );

endinterface

// File: rtl/iter_muldiv_addsub_w.sv
// (WIDTH+1)-bit adder/subtractor shared by the multiply add step and the
// divide trial subtraction.
//   x, y : operands          sub  : 1 = x - y, 0 = x + y
//   res  : sum / difference  cout : carry out (add) or borrow out (subtract)
module iter_muldiv_addsub_w #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0] x,
  input  logic [WIDTH:0] y,
  input  logic           sub,
  output logic [WIDTH:0] res,
  output logic           cout
);

  // One extra bit on top captures the carry, or the borrow as a wrapped 1.
  always_comb begin
    if (sub) {cout, res} = {1'b0, x} - {1'b0, y};
    else     {cout, res} = {1'b0, x} + {1'b0, y};
  end

endmodule

// File: rtl/iter_muldiv.sv
// Multicycle unsigned multiply/divide unit, one bit per cycle.
//   CLK   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : slave side of iter_muldiv_if (start/op/operands in,
//           busy/done/div_zero/result out)
// Multiply is radix-2 shift-add into {acc,lo}; divide is restoring with the
// partial remainder in acc and the quotient shifting through lo. The two
// operations share acc/lo/opnd and the one adder/subtractor.
module iter_muldiv
  import iter_muldiv_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic          CLK,
  input  logic          reset,
  iter_muldiv_if.slave  bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q;
  op_e                op_q;
  logic [WIDTH-1:0]   opnd_q;     // multiplicand or divisor
  logic [WIDTH-1:0]   acc_q;      // product high half or partial remainder
  logic [WIDTH-1:0]   lo_q;       // product low half / multiplier or quotient / dividend
  logic [WIDTH-1:0]   result_q;
  logic               div_zero_q;

  logic               accept;
  logic               last;
  logic [WIDTH:0]     add_x, add_y, add_res;
  logic               add_cout;
  logic [WIDTH:0]     mul_sel;
  logic [WIDTH-1:0]   acc_n, lo_n;

  assign accept = bus.start && (state_q != ST_RUN);
  assign last   = (state_q == ST_RUN) && (count_q == CNT_W'(WIDTH - 1));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN:  if (last)      state_d = ST_DONE;
      ST_DONE: state_d = bus.start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Divide shifts the next dividend bit into a (WIDTH+1)-bit trial remainder
  // so a divisor with its MSB set is still handled correctly.
  always_comb begin
    add_x = is_div(op_q) ? {acc_q, lo_q[WIDTH-1]} : {1'b0, acc_q};
    add_y = {1'b0, opnd_q};
  end

  iter_muldiv_addsub_w #(.WIDTH(WIDTH)) u_addsub (
    .x    (add_x),
    .y    (add_y),
    .sub  (is_div(op_q)),
    .res  (add_res),
    .cout (add_cout)
  );

  always_comb begin
    mul_sel = lo_q[0] ? add_res : {1'b0, acc_q};
    if (is_div(op_q)) begin
      // Borrow means the trial failed: keep the shifted remainder, quotient bit 0.
      acc_n = add_cout ? add_x[WIDTH-1:0] : add_res[WIDTH-1:0];
      lo_n  = {lo_q[WIDTH-2:0], ~add_cout};
    end else begin
      acc_n = mul_sel[WIDTH:1];
      lo_n  = {mul_sel[0], lo_q[WIDTH-1:1]};
    end
  end

  // NOTE: all state, including the datapath registers, resets asynchronously; sequential blocks use <= only.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      op_q       <= OP_MULLO;
      opnd_q     <= '0;
      acc_q      <= '0;
      lo_q       <= '0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= bus.op;
        count_q <= '0;
        acc_q   <= '0;
        if (is_div(bus.op)) begin
          lo_q   <= bus.a_in;
          opnd_q <= bus.b_in;
        end else begin
          lo_q   <= bus.b_in;
          opnd_q <= bus.a_in;
        end
      end else if (state_q == ST_RUN) begin
        acc_q   <= acc_n;
        lo_q    <= lo_n;
        count_q <= count_q + CNT_W'(1);
        if (last) begin
          // MULHI/DIVR come from acc, MULLO/DIVQ from lo.
          result_q   <= op_q[0] ? acc_n : lo_n;
          div_zero_q <= is_div(op_q) && (opnd_q == '0);
        end
      end
    end
  end

  assign bus.busy     = (state_q == ST_RUN);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.result   = result_q;
  assign bus.div_zero = div_zero_q;

endmodule
